// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and context types for the iterative multiply/divide unit.
package muldiv_unit_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_S_IDLE = 2'b00,
      MDU_S_CALC = 2'b01,
      MDU_S_FIX  = 2'b10,
      MDU_S_DONE = 2'b11
   } mdu_state_e;

   // Per-operation context latched at start and consumed by the sign-fix cycle.
   typedef struct packed {
      logic is_div;
      logic neg_lo;
      logic neg_hi;
      logic dbz;
   } mdu_ctx_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply or restoring-divide subtract-shift.
module muldiv_step
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next_c
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Multiply keeps {product_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      shifted    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff       = shifted - {1'b0, operand};
      acc_next_c = {sum, acc[WIDTH-1:1]};
      if (is_div) begin
         if (shifted >= {1'b0, operand}) begin
            acc_next_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next_c = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO.
// Optional MULDIV_MTHILO_EN enables direct HI/LO writes through mthi_we/mtlo_we/wdata.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned W2    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   mdu_state_e       state, state_next;
   logic             accept_c;
   logic [CNT_W-1:0] step_cnt;
   logic [W2-1:0]    acc, acc_step_c;
   logic [WIDTH-1:0] operand;
   mdu_ctx_t         ctx;

   logic             is_signed_c, a_neg_c, b_neg_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;
   logic [W2-1:0]    prod_fix_c;
   logic [WIDTH-1:0] quot_fix_c, rem_fix_c;

   assign is_signed_c = ~op[0];
   assign a_neg_c     = is_signed_c & a[WIDTH-1];
   assign b_neg_c     = is_signed_c & b[WIDTH-1];
   assign a_mag_c     = a_neg_c ? (~a + WIDTH'(1)) : a;
   assign b_mag_c     = b_neg_c ? (~b + WIDTH'(1)) : b;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= MDU_S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == MDU_S_CALC) || (state_next == MDU_S_FIX);
         done  <= (state_next == MDU_S_DONE);
      end
   end

   // Flush overrides everything, including a start arriving in the same cycle.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      case (state)
         MDU_S_IDLE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = MDU_S_CALC;
            end
         end
         MDU_S_CALC: begin
            if (step_cnt == LAST_STEP) state_next = MDU_S_FIX;
         end
         MDU_S_FIX:  state_next = MDU_S_DONE;
         MDU_S_DONE: begin
            if (start) begin
               accept_c   = 1'b1;
               state_next = MDU_S_CALC;
            end else begin
               state_next = MDU_S_IDLE;
            end
         end
         default: state_next = MDU_S_IDLE;
      endcase
      if (flush) begin
         state_next = MDU_S_IDLE;
         accept_c   = 1'b0;
      end
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div     (ctx.is_div),
      .acc        (acc),
      .operand    (operand),
      .acc_next_c (acc_step_c)
   );

   // Operands are latched as magnitudes; signs are reapplied in the fix cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         step_cnt <= '0;
         acc      <= '0;
         operand  <= '0;
         ctx      <= '0;
      end else if (accept_c) begin
         step_cnt    <= '0;
         operand     <= op[1] ? b_mag_c : a_mag_c;
         acc         <= {WIDTH'(0), (op[1] ? a_mag_c : b_mag_c)};
         ctx.is_div  <= op[1];
         ctx.neg_lo  <= a_neg_c ^ b_neg_c;
         ctx.neg_hi  <= op[1] ? a_neg_c : (a_neg_c ^ b_neg_c);
         ctx.dbz     <= op[1] & (b == '0);
      end else if (state == MDU_S_CALC) begin
         step_cnt <= step_cnt + CNT_W'(1);
         acc      <= acc_step_c;
      end
   end

   assign prod_fix_c = ctx.neg_lo ? (~acc + W2'(1)) : acc;
   assign quot_fix_c = ctx.dbz ? '1 :
                       (ctx.neg_lo ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0]);
   assign rem_fix_c  = ctx.neg_hi ? (~acc[W2-1:WIDTH] + WIDTH'(1)) : acc[W2-1:WIDTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept_c) div_by_zero <= 1'b0;
         if (state == MDU_S_FIX) begin
            if (!flush) begin
               if (ctx.is_div) begin
                  hi          <= rem_fix_c;
                  lo          <= quot_fix_c;
                  div_by_zero <= ctx.dbz;
               end else begin
                  hi <= prod_fix_c[W2-1:WIDTH];
                  lo <= prod_fix_c[WIDTH-1:0];
               end
            end
         end
`ifdef MULDIV_MTHILO_EN
         else if (state != MDU_S_CALC) begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
         end
`endif
      end
   end

`ifndef MULDIV_MTHILO_EN
   logic unused_mthilo_c;
   assign unused_mthilo_c = ^{mthi_we, mtlo_we, wdata};
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int unsigned W = 32;

   typedef struct packed {
      logic          dbz;
      logic [W-1:0]  hi;
      logic [W-1:0]  lo;
   } exp_t;

   logic         clk = 1'b0;
   logic         rstn, start, flush, mthi_we, mtlo_we;
   logic [1:0]   op;
   logic [W-1:0] a, b, wdata;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   exp_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] ref_hi = '0;
   logic [W-1:0] ref_lo = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .mthi_we     (mthi_we),
      .mtlo_we     (mtlo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   function automatic exp_t ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t        e;
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e  = '0;
      case (o)
         MDU_MULT: begin
            q = sx * sy;
            p = 64'(q);
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         MDU_MULTU: begin
            p = {32'b0, x} * {32'b0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         MDU_DIV: begin
            if (y == 0) begin
               e.dbz = 1'b1; e.hi = x; e.lo = '1;
            end else begin
               q = sx / sy;
               r = sx % sy;
               p = 64'(q); e.lo = p[31:0];
               p = 64'(r); e.hi = p[31:0];
            end
         end
         default: begin
            if (y == 0) begin
               e.dbz = 1'b1; e.hi = x; e.lo = '1;
            end else begin
               e.lo = x / y;
               e.hi = x % y;
            end
         end
      endcase
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every done pulse retires the oldest expected result.
   always @(negedge clk) begin
      exp_t e;
      if (rstn && done) begin
         if (exp_q.size() == 0) begin
            check("done_without_op", 64'(done), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("hi", 64'(hi), 64'(e.hi));
            check("lo", 64'(lo), 64'(e.lo));
            check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            ref_hi = e.hi;
            ref_lo = e.lo;
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_result);
      start = 1'b1; op = o; a = x; b = y;
      if (expect_result) exp_q.push_back(ref_model(o, x, y));
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(output int nbusy);
      bit got;
      got   = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
         else if (busy) nbusy++;
      end
      if (!got) check("done_timeout", 64'(done), 64'(1));
   endtask

   task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int nb;
      issue(o, x, y, 1'b1);
      wait_done(nb);
      check("busy_cycles", 64'(nb), 64'(33));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return '1;
         3:       return 32'd1;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  nb;
      bit  seen;
      rstn = 1'b0; start = 1'b0; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
      op = '0; a = '0; b = '0; wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_dbz", 64'(div_by_zero), 64'(0));
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
      rstn = 1'b1;
      @(negedge clk);

      run(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'(0));
      check("idle_after_done", 64'(busy), 64'(0));
      run(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
      run(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      run(MDU_DIVU, 32'd100, 32'd7);
      run(MDU_DIVU, 32'd5, 32'd0);
      run(MDU_MULT, 32'd3, 32'd4);
      run(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
      run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run(MDU_DIV, 32'hFFFF_FFF7, 32'd0);
      run(MDU_DIVU, 32'hFFFF_FFFF, 32'd1);

      // Start during CALC must not disturb the running op or queue another.
      issue(MDU_MULT, 32'd1234, 32'hFFFF_FF00, 1'b1);
      repeat (9) @(negedge clk);
      start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(nb);
      check("busy_after_ignored_start", 64'(nb), 64'(24));
      @(negedge clk);
      check("no_queued_start", 64'(busy), 64'(0));

      // Flush in cycle 20 abandons the op and leaves HI/LO alone.
      issue(MDU_MULTU, $urandom, $urandom, 1'b0);
      repeat (19) @(negedge clk);
      @(posedge clk); #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(busy), 64'(0));
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("flush_no_done", 64'(seen), 64'(0));
      check("flush_hi", 64'(hi), 64'(ref_hi));
      check("flush_lo", 64'(lo), 64'(ref_lo));

      // Flush and start together: start is dropped.
      start = 1'b1; flush = 1'b1; op = MDU_MULT; a = 32'd9; b = 32'd9;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_start_busy", 64'(busy), 64'(0));

      // Randomized ops, issued back-to-back on the done cycle.
      for (int i = 0; i < 30; i++) begin
         run(2'($urandom), pick(), pick());
      end

      // Asynchronous reset in the middle of CALC.
      issue(MDU_MULT, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      repeat (10) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_hi", 64'(hi), 64'(0));
      check("midrst_lo", 64'(lo), 64'(0));
      ref_hi = '0; ref_lo = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      run(MDU_DIVU, 32'd1000, 32'd33);

`ifdef MULDIV_MTHILO_EN
      mthi_we = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1; mthi_we = 1'b0;
      check("mthi_idle", 64'(hi), 64'(32'h1234));
      ref_hi = 32'h1234;
      issue(MDU_MULTU, 32'd3, 32'd4, 1'b1);
      mtlo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mtlo_we = 1'b0;
      check("mtlo_busy", 64'(lo), 64'(ref_lo));
      wait_done(nb);
`else
      mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1; mthi_we = 1'b0; mtlo_we = 1'b0;
      check("mthi_ignored", 64'(hi), 64'(ref_hi));
      check("mtlo_ignored", 64'(lo), 64'(ref_lo));
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
